icache_dm: RTL and testbench
============================

# icache_dm

Parametrised direct-mapped, read-only program cache with a clocked refill state machine, sitting between the fetch stage and the memory fill FIFO. It serves 32-bit little-endian reads at any byte address, including reads that span two lines. It refills one line at a time over a valid/ready request and a beat-wise fill stream. A byte-enabled write-update port keeps cached copies coherent with stores to program memory.

## Interface
- ADDR_WIDTH, 32: byte address width.
- LINE_BYTES, 64: bytes per line; power of two, at least 4.
- NUM_LINES, 256: number of lines; power of two.
- FILL_WIDTH, 64: fill beat width in bits; divides LINE_BYTES*8.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- rd_valid  in  1  read request.
- rd_addr  in  ADDR_WIDTH  byte address; held stable while rd_valid && !rd_ready.
- rd_ready  out  1  request accepted this cycle.
- rd_data_valid  out  1  registered; rd_data valid.
- rd_data  out  32  bytes rd_addr..rd_addr+3, byte 0 in [7:0].
- wr_valid  in  1  write-update strobe.
- wr_addr  in  ADDR_WIDTH  byte address.
- wr_data  in  32  write data.
- wr_be  in  4  byte enables.
- inv_all  in  1  invalidate every line.
- mem_req_valid  out  1  refill request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_WIDTH-log2(LINE_BYTES)  line address.
- mem_fill_valid  in  1  fill beat present.
- mem_fill_data  in  FILL_WIDTH  beat; beat 0 is lowest line bytes.

## Operation
- Address split: offset = log2(LINE_BYTES) bits; index = log2(NUM_LINES) bits; tag = the remainder. Each line stores a tag and a valid bit.
- Lookup covers line A = line(rd_addr) and line B = line(rd_addr+3). The +3 wraps modulo 2^ADDR_WIDTH.
- Hit condition: every line touched by the read is valid with a matching tag.
- FSM states: IDLE, REQ, FILL.
- IDLE: rd_ready = rd_valid && hit.
  - On hit, the read is accepted.
  - On miss, the FSM latches the refill line: line A if A misses, else line B. It then moves to REQ.
- REQ: mem_req_valid=1 with mem_req_addr stable. On mem_req_ready the FSM moves to FILL and beat count is 0.
- FILL: each mem_fill_valid writes one beat into the data array at the refill index.
  - On the last beat (LINE_BYTES*8/FILL_WIDTH beats), the tag is written and valid is set, unless poisoned.
  - The FSM then returns to IDLE, and lookup repeats. A line-spanning read therefore does up to two refills.
- Write-update: each byte lane with wr_be set goes to address wr_addr+lane. It is written only if that byte's line hits, and writes may span two lines. Miss lanes are dropped; there is no allocation.
- Poison: a wr_valid lane that targets the line under refill (REQ or FILL) sets poison. A poisoned line installs with valid=0, and the lookup in IDLE re-refills it.
- inv_all: clears all valid bits at the next edge. In REQ/FILL it also sets poison, and the refill completes its handshake without installing.
- inv_all and a hit in the same cycle: the read is accepted with pre-invalidate data.

## Timing
- Hit latency: accepted at edge N; rd_data_valid=1 for exactly one cycle after N; rd_data is held until the next accept.
- Miss: mem_req_valid is asserted the cycle after the miss is detected. After the last fill beat edge, the earliest accept is 1 cycle later.
- mem_fill_valid outside FILL is ignored.
- Reset values: rd_ready=0, rd_data_valid=0, rd_data=0, mem_req_valid=0, mem_req_addr=0, all valid bits=0, poison=0, state=IDLE.
- Reset mid-refill abandons the transaction. The memory side is reset by the same reset.

## Configuration
- ICACHE_PERF_EN defined: adds outputs hit_count and miss_count, each 32 bits.
  - hit_count increments per accepted read. miss_count increments per IDLE→REQ transition.
  - Both reset to 0 and saturate at all-ones.
- Not defined: those ports and counters are absent; all other behaviour is identical.

## Structure
- icache_pkg holds:
  - the state enum (IDLE, REQ, FILL);
  - functions that derive OFFSET_W, INDEX_W, TAG_W and BEATS from the parameters;
  - a line-address helper.
- Sub-module icache_line_store holds the data array, tags and valid bits. It provides:
  - two combinational byte-lookup ports (A and B);
  - a beat-write port;
  - a byte-write port;
  - tag install;
  - valid clear-all.

## Test plan
- Cold read at 0x0000_1000 → REQ with mem_req_addr=0x40, 8 fill beats, then rd_data=bytes 0x1000..0x1003 with rd_data_valid 1 cycle after accept.
- Read at 0x0000_103E (default params) → two refills, lines 0x40 then 0x41; rd_data = {mem[0x1041],mem[0x1040],mem[0x103F],mem[0x103E]}.
- Hit at 0x1000, then write 0xAABBCCDD with wr_be=0101, then read 0x1000 → bytes 0 and 2 updated, bytes 1 and 3 unchanged, no refill.
- A write to line 0x40 during its FILL → line installs invalid, and a second REQ for 0x40 is issued.
- inv_all after a warm hit → the next read at the same address misses.
- Reset asserted during FILL beat 3 → all outputs at their reset values immediately; a subsequent read misses.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_pkg
//  Purpose  : Shared types and helpers for the direct-mapped program cache:
//             refill FSM state encoding, geometry derivation functions and
//             a byte-address to line-address helper.
//  Ports    : none (package)
//  Config   : optional ICACHE_PERF_EN macro is consumed by icache_dm
//  Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } state_e;

  // Byte-offset bits within a line.
  function automatic int calc_offset_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  // Index bits selecting a line (NUM_LINES is expected to be at least 2).
  function automatic int calc_index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Tag bits = whatever remains above index and offset.
  function automatic int calc_tag_w(input int addr_width, input int line_bytes,
                                    input int num_lines);
    return addr_width - $clog2(line_bytes) - $clog2(num_lines);
  endfunction

  // Fill beats needed to complete one line.
  function automatic int calc_beats(input int line_bytes, input int fill_width);
    return (line_bytes * 8) / fill_width;
  endfunction

  // Line address of a byte address (caller truncates to its line width).
  function automatic logic [63:0] line_addr(input logic [63:0] addr,
                                            input int offset_w);
    return addr >> offset_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_store.sv
`default_nettype none
// ============================================================================
//  Module   : icache_line_store
//  Purpose  : Storage for the direct-mapped cache: byte data array, per-line
//             tags and per-line valid bits.
//  Ports    : clock, reset      - clock / async active-high reset (valids only)
//             lka_*             - lookup port A: 4 byte addresses -> per-byte
//                                 hit and byte data (read path)
//             lkb_*             - lookup port B: 4 line addresses -> per-lane
//                                 hit (write-update path)
//             beat_*            - one fill beat into a line
//             byte_*            - up to 4 independent byte writes
//             inst_*            - tag install with the new valid value
//             inv_all           - clear every valid bit
//  Revision : 1.0 - initial release
// ============================================================================
module icache_line_store
  import icache_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int LINE_BYTES = 64,
  parameter  int NUM_LINES  = 256,
  parameter  int FILL_WIDTH = 64,
  localparam int OFFSET_W   = calc_offset_w(LINE_BYTES),
  localparam int INDEX_W    = calc_index_w(NUM_LINES),
  localparam int TAG_W      = calc_tag_w(ADDR_WIDTH, LINE_BYTES, NUM_LINES),
  localparam int BEATS      = calc_beats(LINE_BYTES, FILL_WIDTH),
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int LA_W       = ADDR_WIDTH - OFFSET_W,
  localparam int IO_W       = INDEX_W + OFFSET_W
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [3:0][ADDR_WIDTH-1:0]      lka_addr,
  output logic [3:0]                      lka_hit,
  output logic [31:0]                     lka_data,
  input  logic [3:0][LA_W-1:0]            lkb_line,
  output logic [3:0]                      lkb_hit,
  input  logic                            beat_we,
  input  logic [INDEX_W-1:0]              beat_index,
  input  logic [BEAT_W-1:0]               beat_num,
  input  logic [FILL_WIDTH-1:0]           beat_data,
  input  logic [3:0]                      byte_we,
  input  logic [3:0][IO_W-1:0]            byte_addr,
  input  logic [31:0]                     byte_data,
  input  logic                            inst_we,
  input  logic [INDEX_W-1:0]              inst_index,
  input  logic [TAG_W-1:0]                inst_tag,
  input  logic                            inst_valid,
  input  logic                            inv_all
);

  localparam int FILL_BYTES = FILL_WIDTH / 8;

  logic [7:0]         data_q [NUM_LINES*LINE_BYTES];
  logic [TAG_W-1:0]   tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;

  // Flat byte position of byte j of a fill beat within the data array.
  function automatic logic [IO_W-1:0] beat_byte_addr(input logic [INDEX_W-1:0] idx,
                                                     input logic [BEAT_W-1:0] num,
                                                     input int j);
    logic [OFFSET_W-1:0] off;
    off = OFFSET_W'(int'(num) * FILL_BYTES + j);
    return {idx, off};
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [INDEX_W-1:0] a_idx;
    logic [INDEX_W-1:0] b_idx;

    assign a_idx = lka_addr[i][OFFSET_W +: INDEX_W];
    assign b_idx = lkb_line[i][INDEX_W-1:0];

    assign lka_hit[i] = valid_q[a_idx] &&
                        (tag_q[a_idx] == lka_addr[i][ADDR_WIDTH-1 -: TAG_W]);
    assign lka_data[8*i +: 8] = data_q[lka_addr[i][IO_W-1:0]];
    assign lkb_hit[i] = valid_q[b_idx] &&
                        (tag_q[b_idx] == lkb_line[i][LA_W-1 -: TAG_W]);
  end

  // Write-update bytes first, fill beat last: a refill owns its line.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_we[i]) begin
        data_q[byte_addr[i]] <= byte_data[8*i +: 8];
      end
    end
    if (beat_we) begin
      for (int j = 0; j < FILL_BYTES; j++) begin
        data_q[beat_byte_addr(beat_index, beat_num, j)] <= beat_data[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (inst_we) begin
      tag_q[inst_index] <= inst_tag;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (inv_all) begin
      valid_d = '0;
    end else if (inst_we) begin
      valid_d[inst_index] = inst_valid;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : icache_dm
//  Purpose  : Direct-mapped read-only program cache. Serves 32-bit
//             little-endian reads at any byte address (line-spanning reads
//             refill up to two lines), refills one line at a time, and keeps
//             cached bytes coherent through a byte-enabled write-update port.
//  Ports    : clock, reset                 - clock / async active-high reset
//             rd_valid/rd_addr/rd_ready    - fetch request, accepted on hit
//             rd_data_valid/rd_data        - registered read response
//             wr_valid/wr_addr/wr_data/wr_be - store snoop (update on hit)
//             inv_all                      - invalidate every line
//             mem_req_valid/ready/addr     - refill line request
//             mem_fill_valid/mem_fill_data - refill beat stream
//             hit_count/miss_count         - only with ICACHE_PERF_EN
//  Config   : ICACHE_PERF_EN adds saturating hit/miss counters
//  Revision : 1.0 - initial release
// ============================================================================
module icache_dm
  import icache_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int LINE_BYTES = 64,
  parameter  int NUM_LINES  = 256,
  parameter  int FILL_WIDTH = 64,
  localparam int LA_W       = ADDR_WIDTH - calc_offset_w(LINE_BYTES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_data_valid,
  output logic [31:0]           rd_data,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_be,
  input  logic                  inv_all,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [LA_W-1:0]       mem_req_addr,
  input  logic                  mem_fill_valid,
  input  logic [FILL_WIDTH-1:0] mem_fill_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int OFFSET_W = calc_offset_w(LINE_BYTES);
  localparam int INDEX_W  = calc_index_w(NUM_LINES);
  localparam int TAG_W    = calc_tag_w(ADDR_WIDTH, LINE_BYTES, NUM_LINES);
  localparam int BEATS    = calc_beats(LINE_BYTES, FILL_WIDTH);
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IO_W     = INDEX_W + OFFSET_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                poison_q, poison_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic [LA_W-1:0]     mem_req_addr_q, mem_req_addr_d;
  logic                rd_data_valid_q, rd_data_valid_d;
  logic [31:0]         rd_data_q, rd_data_d;

  logic [3:0][ADDR_WIDTH-1:0] rd_lane_addr;
  logic [3:0][ADDR_WIDTH-1:0] wr_lane_addr;
  logic [3:0][LA_W-1:0]       wr_lane_line;
  logic [3:0][IO_W-1:0]       wr_lane_io;
  logic [3:0]                 rd_lane_hit;
  logic [3:0]                 wr_lane_hit;
  logic [3:0]                 byte_we;
  logic [31:0]                lookup_data;
  logic                       hit;
  logic                       accept;
  logic                       poison_hit;
  logic                       beat_we;
  logic                       inst_we;
  logic [LA_W-1:0]            rd_line_a;
  logic [LA_W-1:0]            rd_line_b;

  // Lane i of a read or write covers byte address+i; the sum wraps naturally.
  for (genvar i = 0; i < 4; i++) begin : g_lane_addr
    assign rd_lane_addr[i] = rd_addr + ADDR_WIDTH'(i);
    assign wr_lane_addr[i] = wr_addr + ADDR_WIDTH'(i);
    assign wr_lane_line[i] = wr_lane_addr[i][ADDR_WIDTH-1:OFFSET_W];
    assign wr_lane_io[i]   = wr_lane_addr[i][IO_W-1:0];
  end

  assign rd_line_a = LA_W'(line_addr(64'(rd_lane_addr[0]), OFFSET_W));
  assign rd_line_b = LA_W'(line_addr(64'(rd_lane_addr[3]), OFFSET_W));

  assign hit = &rd_lane_hit;

  // Stores only touch lanes whose own line is resident; misses are dropped.
  assign byte_we = {4{wr_valid}} & wr_be & wr_lane_hit;

  // Any enabled store lane aimed at the line being fetched makes the
  // incoming copy stale before it lands.
  always_comb begin
    poison_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (wr_valid && wr_be[i] && (wr_lane_line[i] == mem_req_addr_q)) begin
        poison_hit = 1'b1;
      end
    end
  end

  icache_line_store #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LINE_BYTES (LINE_BYTES),
    .NUM_LINES  (NUM_LINES),
    .FILL_WIDTH (FILL_WIDTH)
  ) u_store (
    .clock      (clock),
    .reset      (reset),
    .lka_addr   (rd_lane_addr),
    .lka_hit    (rd_lane_hit),
    .lka_data   (lookup_data),
    .lkb_line   (wr_lane_line),
    .lkb_hit    (wr_lane_hit),
    .beat_we    (beat_we),
    .beat_index (mem_req_addr_q[INDEX_W-1:0]),
    .beat_num   (beat_q),
    .beat_data  (mem_fill_data),
    .byte_we    (byte_we),
    .byte_addr  (wr_lane_io),
    .byte_data  (wr_data),
    .inst_we    (inst_we),
    .inst_index (mem_req_addr_q[INDEX_W-1:0]),
    .inst_tag   (mem_req_addr_q[LA_W-1 -: TAG_W]),
    .inst_valid (!poison_d),
    .inv_all    (inv_all)
  );

  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    poison_d        = poison_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    rd_data_valid_d = 1'b0;
    rd_data_d       = rd_data_q;
    beat_we         = 1'b0;
    inst_we         = 1'b0;
    accept          = 1'b0;

    // Poison taken this cycle counts for an install on this same edge.
    if ((state_q != IDLE) && (inv_all || poison_hit)) begin
      poison_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rd_valid) begin
          if (hit) begin
            accept          = 1'b1;
            rd_data_valid_d = 1'b1;
            rd_data_d       = lookup_data;
          end else begin
            // Byte 0 resident means only the upper line can be missing.
            mem_req_addr_d  = rd_lane_hit[0] ? rd_line_b : rd_line_a;
            mem_req_valid_d = 1'b1;
            poison_d        = 1'b0;
            state_d         = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          beat_d          = '0;
          state_d         = FILL;
        end
      end
      FILL: begin
        if (mem_fill_valid) begin
          beat_we = 1'b1;
          if (beat_q == LAST_BEAT) begin
            inst_we = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      beat_q          <= '0;
      poison_q        <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      rd_data_valid_q <= 1'b0;
      rd_data_q       <= '0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      poison_q        <= poison_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      rd_data_valid_q <= rd_data_valid_d;
      rd_data_q       <= rd_data_d;
    end
  end

  assign rd_ready      = accept;
  assign rd_data_valid = rd_data_valid_q;
  assign rd_data       = rd_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        miss_start;

  assign miss_start = (state_q == IDLE) && rd_valid && !hit;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (accept && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (miss_start && (miss_count_q != '1)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_dm
//  Purpose  : Directed self-checking bench for icache_dm (default build).
//             Memory contents come from a fixed byte function of address.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_dm;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd_valid;
  logic [31:0] rd_addr;
  logic        rd_ready;
  logic        rd_data_valid;
  logic [31:0] rd_data;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        inv_all;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [25:0] mem_req_addr;
  logic        mem_fill_valid;
  logic [63:0] mem_fill_data;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  icache_dm dut (
    .clock          (clock),
    .reset          (reset),
    .rd_valid       (rd_valid),
    .rd_addr        (rd_addr),
    .rd_ready       (rd_ready),
    .rd_data_valid  (rd_data_valid),
    .rd_data        (rd_data),
    .wr_valid       (wr_valid),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_be          (wr_be),
    .inv_all        (inv_all),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_fill_valid (mem_fill_valid),
    .mem_fill_data  (mem_fill_data)
  );

  // Program memory image: one byte per address.
  function automatic logic [7:0] mb(input logic [31:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  function automatic logic [63:0] mbeat(input logic [25:0] line, input int b);
    logic [31:0] base;
    logic [63:0] r;
    base = {line, 6'b0} + 32'(b * 8);
    for (int j = 0; j < 8; j++) r[8*j +: 8] = mb(base + 32'(j));
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for a refill request, checks its line, then handshakes.
  task automatic wait_req(input string tag, input logic [25:0] line);
    int n;
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req_valid"}, 64'(mem_req_valid), 64'd1);
    check({tag, "_req_addr"}, 64'(mem_req_addr), 64'(line));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check({tag, "_req_drop"}, 64'(mem_req_valid), 64'd0);
  endtask

  task automatic send_beats(input logic [25:0] line, input int first, input int last);
    for (int b = first; b <= last; b++) begin
      mem_fill_valid = 1'b1;
      mem_fill_data  = mbeat(line, b);
      tick();
    end
    mem_fill_valid = 1'b0;
  endtask

  // rd_valid/rd_addr already driven; expects acceptance this cycle.
  task automatic finish_read(input string tag, input logic [31:0] exp);
    #1;
    check({tag, "_ready"}, 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 1'b0;
    check({tag, "_dvalid"}, 64'(rd_data_valid), 64'd1);
    check({tag, "_data"}, 64'(rd_data), 64'(exp));
    tick();
    check({tag, "_dvalid_drop"}, 64'(rd_data_valid), 64'd0);
    check({tag, "_data_hold"}, 64'(rd_data), 64'(exp));
  endtask

  task automatic start_miss(input string tag, input logic [31:0] addr);
    rd_valid = 1'b1;
    rd_addr  = addr;
    #1;
    check({tag, "_miss"}, 64'(rd_ready), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; rd_valid = 1'b0; rd_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    inv_all = 1'b0; mem_req_ready = 1'b0; mem_fill_valid = 1'b0; mem_fill_data = '0;
    #2 reset = 1'b1;
    tick(); tick();
    check("rst_rd_ready", 64'(rd_ready), 64'd0);
    check("rst_dvalid", 64'(rd_data_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_req_addr", 64'(mem_req_addr), 64'd0);
    reset = 1'b0;
    tick();

    // Cold read: one refill of line 0x40.
    start_miss("cold", 32'h0000_1000);
    wait_req("cold", 26'h40);
    send_beats(26'h40, 0, 7);
    finish_read("cold", mword(32'h0000_1000));

    // Write-update bytes 0 and 2 of a resident line, then re-read.
    wr_valid = 1'b1; wr_addr = 32'h0000_1000; wr_data = 32'hAABB_CCDD; wr_be = 4'b0101;
    tick();
    wr_valid = 1'b0; wr_be = 4'b0000;
    rd_valid = 1'b1; rd_addr = 32'h0000_1000;
    finish_read("wr_upd", {mb(32'h1003), 8'hBB, mb(32'h1001), 8'hDD});
    check("wr_upd_no_req", 64'(mem_req_valid), 64'd0);

    // Store spanning into a non-resident line: upper lanes are dropped.
    wr_valid = 1'b1; wr_addr = 32'h0000_103E; wr_data = 32'h1122_3344; wr_be = 4'b1111;
    tick();
    wr_valid = 1'b0; wr_be = 4'b0000;
    rd_valid = 1'b1; rd_addr = 32'h0000_103C;
    finish_read("wr_span", {8'h33, 8'h44, mb(32'h103D), mb(32'h103C)});

    // inv_all together with a hit: accepted with pre-invalidate data.
    rd_valid = 1'b1; rd_addr = 32'h0000_1004; inv_all = 1'b1;
    #1;
    check("inv_hit_ready", 64'(rd_ready), 64'd1);
    tick();
    inv_all = 1'b0; rd_valid = 1'b0;
    check("inv_hit_data", 64'(rd_data), 64'(mword(32'h0000_1004)));

    // Same line now misses; a store during FILL poisons the refill.
    start_miss("inv", 32'h0000_1000);
    wait_req("poison1", 26'h40);
    send_beats(26'h40, 0, 2);
    mem_fill_valid = 1'b1; mem_fill_data = mbeat(26'h40, 3);
    wr_valid = 1'b1; wr_addr = 32'h0000_1010; wr_data = 32'h0000_00FF; wr_be = 4'b0001;
    tick();
    wr_valid = 1'b0; wr_be = 4'b0000;
    send_beats(26'h40, 4, 7);
    #1;
    check("poison_still_miss", 64'(rd_ready), 64'd0);
    wait_req("poison2", 26'h40);
    send_beats(26'h40, 0, 7);
    finish_read("poison", mword(32'h0000_1000));

    // Line-spanning read from cold: refills 0x40 then 0x41.
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    start_miss("span", 32'h0000_103E);
    wait_req("span_a", 26'h40);
    send_beats(26'h40, 0, 7);
    wait_req("span_b", 26'h41);
    send_beats(26'h41, 0, 7);
    finish_read("span", mword(32'h0000_103E));

    // Read at the top of the address space wraps into line 0.
    start_miss("wrap", 32'hFFFF_FFFE);
    wait_req("wrap_a", 26'h3FF_FFFF);
    send_beats(26'h3FF_FFFF, 0, 7);
    wait_req("wrap_b", 26'h0);
    send_beats(26'h0, 0, 7);
    finish_read("wrap", mword(32'hFFFF_FFFE));

    // Reset during FILL beat 3.
    start_miss("rstfill", 32'h0000_2000);
    wait_req("rstfill", 26'h80);
    send_beats(26'h80, 0, 2);
    mem_fill_valid = 1'b1; mem_fill_data = mbeat(26'h80, 3);
    #2 reset = 1'b1;
    #1;
    check("rstfill_rd_ready", 64'(rd_ready), 64'd0);
    check("rstfill_dvalid", 64'(rd_data_valid), 64'd0);
    check("rstfill_rd_data", 64'(rd_data), 64'd0);
    check("rstfill_req_valid", 64'(mem_req_valid), 64'd0);
    check("rstfill_req_addr", 64'(mem_req_addr), 64'd0);
    mem_fill_valid = 1'b0; rd_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    start_miss("post_rst", 32'h0000_1000);
    wait_req("post_rst", 26'h40);
    send_beats(26'h40, 0, 7);
    finish_read("post_rst", mword(32'h0000_1000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
